branch_resolve: RTL and testbench
=================================

BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 Parameter IDATAW, default 32: operand, PC and immediate width, minimum 8.
REQ-002 Parameter CNTW, default 16: width of the statistics counters.
REQ-003 Port clk  input  1: single clock; all state updates on the rising edge.
REQ-004 Port rst_n  input  1: reset, asynchronous and active-low.
REQ-005 Port in_valid  input  1: request present.
REQ-006 Port in_ready  output  1: block can accept a request this cycle.
REQ-007 Port idata1, idata2  input  IDATAW each: compare operands (rs1, rs2).
REQ-008 Port funct3  input  3: branch mode.
REQ-009 Port pc, imm  input  IDATAW each: branch PC and sign-extended offset.
REQ-010 Port pred_taken  input  1: front-end prediction for this branch.
REQ-011 Port flush  input  1: kill the held result and block acceptance this cycle.
REQ-012 Port out_valid  output  1: result register holds a valid result.
REQ-013 Port out_ready  input  1: consumer accepts the result.
REQ-014 Port br_taken, mispredict, illegal, misalign  output  1 each: result flags.
REQ-015 Port redirect_pc  output  IDATAW: resolved next PC.
REQ-016 Port br_count, mispred_count  output  CNTW each: statistics counters.

Function
REQ-017 in_ready SHALL equal (!out_valid || out_ready) && !flush, combinationally.
REQ-018 Accept SHALL be in_valid && in_ready; accepted request results appear on the registered outputs exactly 1 cycle later with out_valid=1.
REQ-019 Mode decode SHALL be: 000 BEQ, 001 BNE, 100 BLT (signed), 101 BGE (signed), 110 BLTU, 111 BGEU.
REQ-020 Signed compares SHALL use two's complement; unsigned compares SHALL use raw magnitude.
REQ-021 funct3 010 or 011 SHALL set illegal=1, br_taken=0, mispredict=0, misalign=0, and redirect_pc=pc+4.
REQ-022 The target SHALL be pc+imm modulo 2^IDATAW; the fall-through SHALL be pc+4 modulo 2^IDATAW.
REQ-023 redirect_pc SHALL be the target when br_taken=1, else the fall-through.
REQ-024 mispredict SHALL equal br_taken XOR pred_taken for legal modes.
REQ-025 misalign SHALL be 1 iff br_taken=1 and target[1:0]!=0.
REQ-026 Outputs SHALL hold stable while out_valid=1 and out_ready=0.
REQ-027 When out_valid && out_ready, with no same-cycle accept, out_valid SHALL clear next cycle.
REQ-028 Back-to-back: a handoff plus accept in the same cycle SHALL load the new result; out_valid stays 1.
REQ-029 flush=1 SHALL clear out_valid next cycle regardless of out_ready; no accept occurs that cycle.
REQ-030 br_count SHALL increment on each handoff (out_valid && out_ready && !flush) of a legal result.
REQ-031 mispred_count SHALL increment on each such handoff with mispredict=1.
REQ-032 Both counters SHALL saturate at all-ones, not wrap.
REQ-033 Illegal results SHALL be handed off normally but SHALL NOT be counted.

Reset
REQ-034 rst_n=0 SHALL asynchronously clear out_valid, br_taken, mispredict, illegal, misalign, redirect_pc, br_count and mispred_count to 0.
REQ-035 Reset mid-transaction SHALL discard the held result; in_ready SHALL be 1 in the first cycle after release, flush=0.

Verification
REQ-036 BLT with idata1=0xFFFFFFFF, idata2=1, pc=0x100, imm=0x20, pred_taken=0 -> next cycle br_taken=1, redirect_pc=0x120, mispredict=1.
REQ-037 Same operands, funct3=110 (BLTU) -> br_taken=0, redirect_pc=0x104, mispredict=0.
REQ-038 Hold out_ready=0 for 3 cycles after accept -> in_ready=0, outputs constant; then out_ready=1 with a new in_valid -> back-to-back load, br_count+1.
REQ-039 funct3=011 -> illegal=1, br_taken=0, counters unchanged after handoff; BEQ taken with imm=0x2 -> misalign=1.
REQ-040 CNTW=4, 17 mispredicted handoffs -> br_count=mispred_count=0xF.
REQ-041 flush with out_valid=1, out_ready=0 -> out_valid=0 next cycle, no count; rst_n low mid-hold -> all outputs 0 immediately.

Source files
------------

// File: rtl/branch_resolve.sv
// Branch resolution stage: compares operands, picks the next PC, flags mispredicts,
// and holds one registered result behind a valid/ready handshake with saturating statistics.
module branch_resolve #(
   parameter int IDATAW = 32,
   parameter int CNTW   = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [IDATAW-1:0] idata1,
   input  logic [IDATAW-1:0] idata2,
   input  logic [2:0]        funct3,
   input  logic [IDATAW-1:0] pc,
   input  logic [IDATAW-1:0] imm,
   input  logic              pred_taken,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              br_taken,
   output logic              mispredict,
   output logic              illegal,
   output logic              misalign,
   output logic [IDATAW-1:0] redirect_pc,
   output logic [CNTW-1:0]   br_count,
   output logic [CNTW-1:0]   mispred_count
);

   logic              accept;
   logic              handoff;
   logic              cond;
   logic              res_illegal;
   logic              res_taken;
   logic              res_mispredict;
   logic              res_misalign;
   logic [IDATAW-1:0] target;
   logic [IDATAW-1:0] fall_thru;
   logic [IDATAW-1:0] res_pc;

   assign in_ready = (!out_valid || out_ready) && !flush;
   assign accept   = in_valid && in_ready;
   assign handoff  = out_valid && out_ready && !flush;

   assign target    = pc + imm;
   assign fall_thru = pc + IDATAW'(4);

   always_comb begin
      cond        = 1'b0;
      res_illegal = 1'b0;
      case (funct3)
         3'b000:  cond = (idata1 == idata2);
         3'b001:  cond = (idata1 != idata2);
         3'b100:  cond = ($signed(idata1) <  $signed(idata2));
         3'b101:  cond = ($signed(idata1) >= $signed(idata2));
         3'b110:  cond = (idata1 <  idata2);
         3'b111:  cond = (idata1 >= idata2);
         default: res_illegal = 1'b1;
      endcase
   end

   // Illegal modes force every flag low so the consumer only sees the fall-through.
   assign res_taken      = cond && !res_illegal;
   assign res_mispredict = !res_illegal && (res_taken ^ pred_taken);
   assign res_misalign   = res_taken && (target[1:0] != 2'b00);
   assign res_pc         = res_taken ? target : fall_thru;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid   <= 1'b0;
         br_taken    <= 1'b0;
         mispredict  <= 1'b0;
         illegal     <= 1'b0;
         misalign    <= 1'b0;
         redirect_pc <= '0;
      end else begin
         if (flush) begin
            out_valid <= 1'b0;
         end else if (accept) begin
            out_valid <= 1'b1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
         if (accept) begin
            br_taken    <= res_taken;
            mispredict  <= res_mispredict;
            illegal     <= res_illegal;
            misalign    <= res_misalign;
            redirect_pc <= res_pc;
         end
      end
   end

   // Statistics count results as they leave, never as they enter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         br_count      <= '0;
         mispred_count <= '0;
      end else if (handoff && !illegal) begin
         if (br_count != {CNTW{1'b1}}) begin
            br_count <= br_count + CNTW'(1);
         end
         if (mispredict && (mispred_count != {CNTW{1'b1}})) begin
            mispred_count <= mispred_count + CNTW'(1);
         end
      end
   end

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve: vector table for the compare/redirect logic,
// plus hand sequences for stall, back-to-back, flush, saturation and async reset.
module tb_branch_resolve;

   localparam int IDATAW = 32;
   localparam int CNTW   = 4;

   logic              clk;
   logic              rst_n;
   logic              in_valid;
   logic              in_ready;
   logic [IDATAW-1:0] idata1;
   logic [IDATAW-1:0] idata2;
   logic [2:0]        funct3;
   logic [IDATAW-1:0] pc;
   logic [IDATAW-1:0] imm;
   logic              pred_taken;
   logic              flush;
   logic              out_valid;
   logic              out_ready;
   logic              br_taken;
   logic              mispredict;
   logic              illegal;
   logic              misalign;
   logic [IDATAW-1:0] redirect_pc;
   logic [CNTW-1:0]   br_count;
   logic [CNTW-1:0]   mispred_count;

   branch_resolve #(.IDATAW(IDATAW), .CNTW(CNTW)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .idata1        (idata1),
      .idata2        (idata2),
      .funct3        (funct3),
      .pc            (pc),
      .imm           (imm),
      .pred_taken    (pred_taken),
      .flush         (flush),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .br_taken      (br_taken),
      .mispredict    (mispredict),
      .illegal       (illegal),
      .misalign      (misalign),
      .redirect_pc   (redirect_pc),
      .br_count      (br_count),
      .mispred_count (mispred_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]        f3;
      logic [IDATAW-1:0] a;
      logic [IDATAW-1:0] b;
      logic [IDATAW-1:0] vpc;
      logic [IDATAW-1:0] vimm;
      logic              pred;
      logic              tk;
      logic              mis;
      logic              ill;
      logic              mal;
      logic [IDATAW-1:0] rpc;
   } vec_t;

   vec_t vecs [10];

   int tests;
   int fails;
   int exp_br;
   int exp_mp;
   logic [IDATAW-1:0] held_pc;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      funct3     = v.f3;
      idata1     = v.a;
      idata2     = v.b;
      pc         = v.vpc;
      imm        = v.vimm;
      pred_taken = v.pred;
   endtask

   task automatic chk_result(input string tag, input vec_t v);
      chk({tag, ".out_valid"},   64'(out_valid),   64'(1'b1));
      chk({tag, ".br_taken"},    64'(br_taken),    64'(v.tk));
      chk({tag, ".mispredict"},  64'(mispredict),  64'(v.mis));
      chk({tag, ".illegal"},     64'(illegal),     64'(v.ill));
      chk({tag, ".misalign"},    64'(misalign),    64'(v.mal));
      chk({tag, ".redirect_pc"}, 64'(redirect_pc), 64'(v.rpc));
   endtask

   task automatic model_handoff(input vec_t v);
      if (!v.ill) begin
         if (exp_br < 15) exp_br++;
         if (v.mis && exp_mp < 15) exp_mp++;
      end
   endtask

   task automatic chk_counts(input string tag);
      chk({tag, ".br_count"},      64'(br_count),      64'(exp_br));
      chk({tag, ".mispred_count"}, 64'(mispred_count), 64'(exp_mp));
   endtask

   initial begin
      tests = 0; fails = 0; exp_br = 0; exp_mp = 0;
      //          f3      a              b              pc             imm            pr  tk  mis ill mal rpc
      vecs[0] = '{3'b100, 32'hFFFFFFFF, 32'h00000001, 32'h00000100, 32'h00000020, 0, 1, 1, 0, 0, 32'h00000120};
      vecs[1] = '{3'b110, 32'hFFFFFFFF, 32'h00000001, 32'h00000100, 32'h00000020, 0, 0, 0, 0, 0, 32'h00000104};
      vecs[2] = '{3'b000, 32'h00000005, 32'h00000005, 32'h00000200, 32'h00000002, 1, 1, 0, 0, 1, 32'h00000202};
      vecs[3] = '{3'b001, 32'h00000005, 32'h00000005, 32'h00000200, 32'h00000008, 1, 0, 1, 0, 0, 32'h00000204};
      vecs[4] = '{3'b101, 32'h80000000, 32'h00000000, 32'h00001000, 32'h00000040, 0, 0, 0, 0, 0, 32'h00001004};
      vecs[5] = '{3'b111, 32'h80000000, 32'h00000000, 32'h00001000, 32'hFFFFFFF0, 0, 1, 1, 0, 0, 32'h00000FF0};
      vecs[6] = '{3'b011, 32'h00000003, 32'h00000003, 32'h00000300, 32'h00000010, 1, 0, 0, 1, 0, 32'h00000304};
      vecs[7] = '{3'b010, 32'h00000001, 32'h00000002, 32'hFFFFFFFC, 32'h00000010, 0, 0, 0, 1, 0, 32'h00000000};
      vecs[8] = '{3'b101, 32'h00000007, 32'h00000007, 32'hFFFFFFF0, 32'h00000020, 1, 1, 0, 0, 0, 32'h00000010};
      vecs[9] = '{3'b100, 32'h00000001, 32'hFFFFFFFF, 32'h00000040, 32'h00000100, 1, 0, 1, 0, 0, 32'h00000044};

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
      drive(vecs[0]);
      repeat (2) @(negedge clk);
      chk("reset.out_valid", 64'(out_valid), 64'd0);
      chk("reset.redirect_pc", 64'(redirect_pc), 64'd0);
      chk("reset.flags", 64'({br_taken, mispredict, illegal, misalign}), 64'd0);
      chk_counts("reset");
      rst_n = 1'b1;
      #1 chk("reset.in_ready", 64'(in_ready), 64'd1);

      // Table: accept, check one cycle later, then drain and check counters.
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         drive(vecs[i]); in_valid = 1'b1; out_ready = 1'b0;
         @(negedge clk);
         chk_result($sformatf("vec%0d", i), vecs[i]);
         in_valid = 1'b0; out_ready = 1'b1;
         @(negedge clk);
         model_handoff(vecs[i]);
         chk($sformatf("vec%0d.drain", i), 64'(out_valid), 64'd0);
         chk_counts($sformatf("vec%0d", i));
      end

      // Stall for 3 cycles, then back-to-back handoff plus accept.
      drive(vecs[0]); in_valid = 1'b1; out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      held_pc = redirect_pc;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk($sformatf("hold%0d.in_ready", i), 64'(in_ready), 64'd0);
         chk_result($sformatf("hold%0d", i), vecs[0]);
         chk_counts($sformatf("hold%0d", i));
         @(negedge clk);
      end
      chk("hold.redirect_stable", 64'(redirect_pc), 64'(held_pc));
      drive(vecs[1]); in_valid = 1'b1; out_ready = 1'b1;
      #1 chk("b2b.in_ready", 64'(in_ready), 64'd1);
      @(negedge clk);
      model_handoff(vecs[0]);
      chk_result("b2b", vecs[1]);
      chk_counts("b2b");
      in_valid = 1'b0;
      @(negedge clk);
      model_handoff(vecs[1]);
      chk("b2b.drain", 64'(out_valid), 64'd0);
      chk_counts("b2b.drain");

      // Flush while held: no accept, no count.
      drive(vecs[3]); in_valid = 1'b1; out_ready = 1'b0;
      @(negedge clk);
      chk_result("preflush", vecs[3]);
      drive(vecs[0]); flush = 1'b1; out_ready = 1'b0;
      #1 chk("flush.in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
      flush = 1'b0; in_valid = 1'b0;
      chk("flush.out_valid", 64'(out_valid), 64'd0);
      chk_counts("flush");

      // 17 mispredicted handoffs must saturate both 4-bit counters.
      drive(vecs[0]); out_ready = 1'b1;
      for (int i = 0; i < 17; i++) begin
         in_valid = 1'b1;
         @(negedge clk);
         model_handoff(vecs[0]);
      end
      in_valid = 1'b0;
      @(negedge clk);
      chk("sat.br_count", 64'(br_count), 64'hF);
      chk("sat.mispred_count", 64'(mispred_count), 64'hF);
      chk_counts("sat");

      // Async reset while a result is held.
      drive(vecs[2]); in_valid = 1'b1; out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      chk_result("prerst", vecs[2]);
      #2 rst_n = 1'b0;
      #1;
      exp_br = 0; exp_mp = 0;
      chk("rst.out_valid", 64'(out_valid), 64'd0);
      chk("rst.redirect_pc", 64'(redirect_pc), 64'd0);
      chk("rst.flags", 64'({br_taken, mispredict, illegal, misalign}), 64'd0);
      chk_counts("rst");
      @(negedge clk);
      rst_n = 1'b1; flush = 1'b0; out_ready = 1'b0;
      @(posedge clk);
      #1 chk("rst.in_ready", 64'(in_ready), 64'd1);
      chk("rst.out_valid_after", 64'(out_valid), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
